time_edit: RTL and testbench
============================

# time_edit

Front-panel time-setting controller for the digital clock. It turns five raw push-buttons into the one-hot digit `cursor`, six BCD digit values `n_*`, and an `edit` level. These outputs drive the load side of the countdown timer and clock blocks, which copy the cursor-selected digit while `edit` is high. It owns edit-mode entry and exit, cursor movement, and per-digit increment and decrement with time-legal wrap limits.

## Interface
- `DB_CYCLES`, default 20000: number of consecutive stable synchronized samples required before a button level is accepted. Used only with debounce compiled in.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `btn_mode` in 1: raw, asynchronous button; enters and leaves edit mode.
- `btn_left` in 1: raw button; moves the cursor toward `hrs1`.
- `btn_right` in 1: raw button; moves the cursor toward `sec0`.
- `btn_up` in 1: raw button; increments the selected digit.
- `btn_down` in 1: raw button; decrements the selected digit.
- `edit` out 1: high while in EDIT state.
- `cursor` out 6: one-hot digit select, or 0 when idle.
  - bit0 = `sec0`, bit1 = `sec1`, bit2 = `min0`, bit3 = `min1`, bit4 = `hrs0`, bit5 = `hrs1`.
- `commit` out 1: one-cycle pulse on exit from EDIT.
- `n_sec0`, `n_sec1`, `n_min0`, `n_min1`, `n_hrs0`, `n_hrs1` out 4 each: BCD digit values being edited.

## Operation
- **Reset values:** state IDLE, `edit`=0, `cursor`=0, `commit`=0, all `n_*`=0.
- **Button conditioning:** each button passes through a 2-flop synchronizer, optional debounce, then rising-edge detect. The result is a one-cycle press event.
- **IDLE state:**
  - Mode press moves to EDIT and sets `cursor`=000001. Digits are retained from the previous edit.
  - Arrow presses are ignored.
- **EDIT state:**
  - Mode press moves to IDLE, sets `cursor`=0, and pulses `commit` for 1 cycle.
  - Left press: `cursor` rotates left; 100000 wraps to 000001.
  - Right press: `cursor` rotates right; 000001 wraps to 100000.
  - Up press increments the selected digit, wrapping at the limit to 0:
    - `sec0`, `min0`: 9→0.
    - `sec1`, `min1`: 5→0.
    - `hrs1`: 2→0.
    - `hrs0`: 9→0, or 3→0 when `n_hrs1`=2.
  - Down press decrements the selected digit; 0 wraps to that digit's current limit.
- **Hours legality (24 h):** any cycle that sets `n_hrs1` to 2 while `n_hrs0`>3 also sets `n_hrs0`=3 in the same cycle. `n_hrs0` never exceeds 3 while `n_hrs1`=2.
- **Simultaneous press events in one cycle:** priority is mode > left > right > up > down. Only the highest-priority event is acted on; the others are discarded, not queued.
- **Held button:** produces exactly one event. There is no auto-repeat.
- **Out-of-range digits:** no input path can create one. They are unreachable.

## Timing
- **No debounce:** a raw button high sampled at edge k produces the press event combinationally in cycle k+2. The registered outputs update at edge k+3.
- **With debounce:** the event occurs DB_CYCLES cycles later than without debounce.
- **`commit`:** high for exactly the one cycle in which `edit` first reads 0.
- **Reset asserted mid-edit:** all outputs return to reset values immediately (asynchronous). Debounce counters and synchronizers clear.
- A button held through reset deassertion produces no event until it is released and pressed again. The edge detector's previous-level flop resets to 1.

## Configuration
- `TIME_EDIT_DEBOUNCE_EN` defined: each button has a counter sized by `$clog2(DB_CYCLES+1)`.
  - The counter resets whenever the synchronized level differs from the accepted level.
  - The accepted level toggles when the counter reaches DB_CYCLES.
  - Bounces shorter than DB_CYCLES produce no event.
- `TIME_EDIT_DEBOUNCE_EN` undefined: the accepted level equals the synchronized level. `DB_CYCLES` is unused.

## Structure
- **Package `time_pkg`:**
  - digit limits `SEC0_MAX`=9, `SEC1_MAX`=5, `MIN0_MAX`=9, `MIN1_MAX`=5, `HRS0_MAX`=9, `HRS0_MAX_AT_2`=3, `HRS1_MAX`=2;
  - cursor one-hot localparams `CUR_SEC0` through `CUR_HRS1`;
  - state enum {IDLE, EDIT}.
- **Sub-module `btn_cond`:** synchronizer, optional debounce, and rise detect. Instantiated 5 times. Output is a `press` pulse.

## Test plan
- **Reset and entry:** reset, then a mode press → `edit`=1, `cursor`=000001, all digits 0; one mode press later → `edit`=0, `cursor`=0, `commit` high for 1 cycle.
- **Cursor wrap:** in EDIT, 6 left presses from 000001 → 000010, 000100, 001000, 010000, 100000, 000001; one right press → 100000.
- **Digit wrap:**
  - `sec1` selected, 6 up presses → 1,2,3,4,5,0;
  - one down press at 0 → 5;
  - `sec0` down from 0 → 9.
- **Hours clamp:**
  - set `n_hrs0`=7, then up `n_hrs1` 0→1→2 → `n_hrs0` becomes 3 in the same cycle;
  - then up on `hrs0` at 3 → 0.
- **Priority and idle:**
  - left+up pressed in the same cycle in EDIT → only the cursor moves, digit unchanged;
  - up press in IDLE → no change.
- **Debounce (`TIME_EDIT_DEBOUNCE_EN`, DB_CYCLES=8):**
  - 5-cycle glitch → no event;
  - 12-cycle hold → exactly one event;
  - reset asserted mid-hold → outputs at reset values, no event after reset release until re-press.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants for the front-panel time-setting controller: digit wrap
// limits, one-hot cursor codes, edit-mode state encoding.
package time_pkg;

  localparam logic [3:0] SEC0_MAX      = 4'd9;
  localparam logic [3:0] SEC1_MAX      = 4'd5;
  localparam logic [3:0] MIN0_MAX      = 4'd9;
  localparam logic [3:0] MIN1_MAX      = 4'd5;
  localparam logic [3:0] HRS0_MAX      = 4'd9;
  localparam logic [3:0] HRS0_MAX_AT_2 = 4'd3;
  localparam logic [3:0] HRS1_MAX      = 4'd2;

  localparam logic [5:0] CUR_SEC0 = 6'b000001;
  localparam logic [5:0] CUR_SEC1 = 6'b000010;
  localparam logic [5:0] CUR_MIN0 = 6'b000100;
  localparam logic [5:0] CUR_MIN1 = 6'b001000;
  localparam logic [5:0] CUR_HRS0 = 6'b010000;
  localparam logic [5:0] CUR_HRS1 = 6'b100000;

  localparam int unsigned NUM_DIGITS = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  // Wrap limit of digit idx (0 = sec0 .. 5 = hrs1); hrs0 tightens to 3 in the 20s.
  function automatic logic [3:0] digit_max(input int unsigned idx, input logic [3:0] hrs1);
    logic [3:0] lim;
    case (idx)
      0:       lim = SEC0_MAX;
      1:       lim = SEC1_MAX;
      2:       lim = MIN0_MAX;
      3:       lim = MIN1_MAX;
      4:       lim = (hrs1 == HRS1_MAX) ? HRS0_MAX_AT_2 : HRS0_MAX;
      default: lim = HRS1_MAX;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/time_edit_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Debounce is compiled in with TIME_EDIT_DEBOUNCE_EN.
module btn_cond #(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic s1, s2, acc, prev;

  // Whole pipeline resets to "pressed" so a button held across reset must be
  // released and pressed again before it yields an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef TIME_EDIT_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= 1'b1;
    end else if (s2 != acc) begin
      if (cnt == CNT_MAX) begin
        acc <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= 1'b1;
    else     acc <= s2;
  end

  // DB_CYCLES has no effect without debounce; referenced here only so the
  // parameter map stays identical between builds.
  if (DB_CYCLES == 0) begin : g_db_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= acc;
  end

  assign press = acc & ~prev;

endmodule

// File: rtl/time_edit.sv
// Front-panel time-setting controller: edit mode, cursor movement, per-digit
// up/down with 24 h legal wrap. Optional debounce via TIME_EDIT_DEBOUNCE_EN.
module time_edit
  import time_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       edit,
  output logic [5:0] cursor,
  output logic       commit,
  output logic [3:0] n_sec0,
  output logic [3:0] n_sec1,
  output logic [3:0] n_min0,
  output logic [3:0] n_min1,
  output logic [3:0] n_hrs0,
  output logic [3:0] n_hrs1
);

  logic p_mode, p_left, p_right, p_up, p_down;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_mode  (.clk(clk), .rst(rst), .raw(btn_mode),  .press(p_mode));
  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_left  (.clk(clk), .rst(rst), .raw(btn_left),  .press(p_left));
  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_right (.clk(clk), .rst(rst), .raw(btn_right), .press(p_right));
  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_up    (.clk(clk), .rst(rst), .raw(btn_up),    .press(p_up));
  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_down  (.clk(clk), .rst(rst), .raw(btn_down),  .press(p_down));

  state_t     state, state_n;
  logic [5:0] cursor_n;
  logic       commit_n;
  logic [3:0] dig   [NUM_DIGITS];
  logic [3:0] dig_n [NUM_DIGITS];
  logic [3:0] lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cursor <= '0;
      commit <= 1'b0;
      dig    <= '{default: '0};
    end else begin
      state  <= state_n;
      cursor <= cursor_n;
      commit <= commit_n;
      dig    <= dig_n;
    end
  end

  always_comb begin
    state_n  = state;
    cursor_n = cursor;
    commit_n = 1'b0;
    dig_n    = dig;
    lim      = '0;
    case (state)
      IDLE: begin
        if (p_mode) begin
          state_n  = EDIT;
          cursor_n = CUR_SEC0;
        end
      end
      EDIT: begin
        if (p_mode) begin
          state_n  = IDLE;
          cursor_n = '0;
          commit_n = 1'b1;
        end else if (p_left) begin
          cursor_n = {cursor[4:0], cursor[5]};
        end else if (p_right) begin
          cursor_n = {cursor[0], cursor[5:1]};
        end else if (p_up || p_down) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cursor[i]) begin
              lim = digit_max(i, dig[5]);
              if (p_up) dig_n[i] = (dig[i] >= lim) ? 4'd0 : dig[i] + 4'd1;
              else      dig_n[i] = (dig[i] == 4'd0) ? lim : dig[i] - 4'd1;
            end
          end
          // Entering the 20s from either direction pulls hrs0 down in the same cycle.
          if (dig_n[5] == HRS1_MAX && dig_n[4] > HRS0_MAX_AT_2)
            dig_n[4] = HRS0_MAX_AT_2;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign edit   = (state == EDIT);
  assign n_sec0 = dig[0];
  assign n_sec1 = dig[1];
  assign n_min0 = dig[2];
  assign n_min1 = dig[3];
  assign n_hrs0 = dig[4];
  assign n_hrs1 = dig[5];

endmodule

// File: tb/tb_time_edit.sv
// Directed bench for time_edit: stimulus pushes hand-computed expectations,
// a monitor pops and compares them when the stimulus flags a check point.
module tb_time_edit;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_left, btn_right, btn_up, btn_down;
  logic       edit, commit;
  logic [5:0] cursor;
  logic [3:0] n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1;
  logic [23:0] digits;

  always #5 clk = ~clk;

  time_edit #(.DB_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down),
    .edit(edit), .cursor(cursor), .commit(commit),
    .n_sec0(n_sec0), .n_sec1(n_sec1), .n_min0(n_min0),
    .n_min1(n_min1), .n_hrs0(n_hrs0), .n_hrs1(n_hrs1)
  );

  assign digits = {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0};

`ifdef TIME_EDIT_DEBOUNCE_EN
  localparam int HOLD = 14;
  localparam int GAP = 16;
  localparam int SETTLE = 20;
`else
  localparam int HOLD = 4;
  localparam int GAP = 4;
  localparam int SETTLE = 6;
`endif

  localparam logic [4:0] M = 5'b10000, L = 5'b01000, R = 5'b00100, U = 5'b00010, DN = 5'b00001;

  typedef struct {
    string       name;
    logic        edit;
    logic [5:0]  cursor;
    logic [23:0] digits;
    int          commits;
  } exp_t;

  exp_t q[$];
  logic chk = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   commits_seen = 0;
  logic prev_edit = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (commit) begin
      commits_seen++;
      n_tests++;
      if (!(prev_edit && !edit)) begin
        n_fail++;
        $display("FAIL commit_pulse: edit prev=%0b now=%0b, required prev=1 now=0", prev_edit, edit);
      end
    end else if (prev_edit && !edit && !rst) begin
      n_tests++;
      n_fail++;
      $display("FAIL commit_missing: commit=0 on edit exit, required 1");
    end
    prev_edit = edit;
    if (chk) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: check requested with no expectation queued");
      end else begin
        e = q.pop_front();
        if (edit !== e.edit || cursor !== e.cursor || digits !== e.digits || commits_seen != e.commits) begin
          n_fail++;
          $display("FAIL %s: edit=%0b cursor=%b digits=%h commits=%0d, required edit=%0b cursor=%b digits=%h commits=%0d",
                   e.name, edit, cursor, digits, commits_seen, e.edit, e.cursor, e.digits, e.commits);
        end
      end
    end
  end

  function automatic logic [23:0] dg(input logic [3:0] h1, h0, m1, m0, s1, s0);
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  task automatic push(input string nm, input logic e, input logic [5:0] c, input logic [23:0] d, input int cm);
    exp_t x;
    x.name = nm; x.edit = e; x.cursor = c; x.digits = d; x.commits = cm;
    q.push_back(x);
  endtask

  // Called at a negedge; the monitor compares on the following posedge.
  task automatic expect_now(input string nm, input logic e, input logic [5:0] c, input logic [23:0] d, input int cm);
    push(nm, e, c, d, cm);
    chk = 1'b1;
    @(negedge clk);
    chk = 1'b0;
  endtask

  task automatic press(input logic [4:0] b, input int hold);
    @(negedge clk);
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = b;
    repeat (hold) @(negedge clk);
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = '0;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: bench did not complete, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [5:0]  lcur [6];
    logic [3:0]  sv   [6];
    lcur = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    sv   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};

    {btn_mode, btn_left, btn_right, btn_up, btn_down} = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (SETTLE) @(negedge clk);
    expect_now("reset", 1'b0, 6'b0, dg(0,0,0,0,0,0), 0);

    press(M, HOLD); expect_now("enter_edit", 1'b1, 6'b000001, dg(0,0,0,0,0,0), 0);
    press(M, HOLD); expect_now("exit_edit", 1'b0, 6'b0, dg(0,0,0,0,0,0), 1);

`ifndef TIME_EDIT_DEBOUNCE_EN
    // Raw high before edge k: unchanged after k+2, updated after k+3.
    btn_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push("latency_k2", 1'b0, 6'b0, dg(0,0,0,0,0,0), 1);
    chk = 1'b1;
    @(negedge clk);
    push("latency_k3", 1'b1, 6'b000001, dg(0,0,0,0,0,0), 1);
    @(negedge clk);
    chk = 1'b0;
    btn_mode = 1'b0;
    repeat (GAP) @(negedge clk);
`else
    press(M, HOLD); expect_now("reenter", 1'b1, 6'b000001, dg(0,0,0,0,0,0), 1);
`endif

    for (int i = 0; i < 6; i++) begin
      press(L, HOLD);
      expect_now($sformatf("left_%0d", i), 1'b1, lcur[i], dg(0,0,0,0,0,0), 1);
    end
    press(R, HOLD); expect_now("right_wrap", 1'b1, 6'b100000, dg(0,0,0,0,0,0), 1);
    for (int i = 0; i < 4; i++) press(R, HOLD);
    expect_now("to_sec1", 1'b1, 6'b000010, dg(0,0,0,0,0,0), 1);

    for (int i = 0; i < 6; i++) begin
      press(U, HOLD);
      expect_now($sformatf("sec1_up_%0d", i), 1'b1, 6'b000010, dg(0,0,0,0,sv[i],0), 1);
    end
    press(DN, HOLD); expect_now("sec1_down_wrap", 1'b1, 6'b000010, dg(0,0,0,0,5,0), 1);
    press(R, HOLD);
    press(DN, HOLD); expect_now("sec0_down_wrap", 1'b1, 6'b000001, dg(0,0,0,0,5,9), 1);

    for (int i = 0; i < 4; i++) press(L, HOLD);
    for (int i = 0; i < 7; i++) press(U, HOLD);
    expect_now("hrs0_seven", 1'b1, 6'b010000, dg(0,7,0,0,5,9), 1);
    press(L, HOLD);
    press(U, HOLD); expect_now("hrs1_to_1", 1'b1, 6'b100000, dg(1,7,0,0,5,9), 1);
    press(U, HOLD); expect_now("hrs_clamp", 1'b1, 6'b100000, dg(2,3,0,0,5,9), 1);
    press(R, HOLD);
    press(U, HOLD); expect_now("hrs0_wrap_at_2", 1'b1, 6'b010000, dg(2,0,0,0,5,9), 1);
    press(DN, HOLD); expect_now("hrs0_down_at_2", 1'b1, 6'b010000, dg(2,3,0,0,5,9), 1);

    press(L | U, HOLD); expect_now("prio_left_up", 1'b1, 6'b100000, dg(2,3,0,0,5,9), 1);
    press(M, HOLD); expect_now("exit_retain", 1'b0, 6'b0, dg(2,3,0,0,5,9), 2);
    press(U, HOLD); expect_now("idle_up_ignored", 1'b0, 6'b0, dg(2,3,0,0,5,9), 2);
    press(M, HOLD); expect_now("reenter_retain", 1'b1, 6'b000001, dg(2,3,0,0,5,9), 2);

    // Mode held into a reset asserted before its event can fire.
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_now("reset_mid_edit", 1'b0, 6'b0, dg(0,0,0,0,0,0), 2);
    rst = 1'b0;
    repeat (HOLD + GAP + 10) @(negedge clk);
    expect_now("held_through_reset", 1'b0, 6'b0, dg(0,0,0,0,0,0), 2);
    btn_mode = 1'b0;
    repeat (GAP) @(negedge clk);
    press(M, HOLD); expect_now("repress_after_reset", 1'b1, 6'b000001, dg(0,0,0,0,0,0), 2);

`ifdef TIME_EDIT_DEBOUNCE_EN
    press(M, 5);  expect_now("db_glitch", 1'b1, 6'b000001, dg(0,0,0,0,0,0), 2);
    press(M, 12); expect_now("db_hold12", 1'b0, 6'b0, dg(0,0,0,0,0,0), 3);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
